// File: rtl/bless_ni_pkg.sv
// Shared widths, control-word field positions and the queued flit record
// for the node-side network interface of the bufferless router.
package bless_ni_pkg;

    localparam int CONTROL_W   = 28;
    localparam int DATA_W      = 128;
    localparam int DEST_W      = 8;
    localparam int AGE_W       = 16;

    localparam int CTL_VALID   = 27;
    localparam int CTL_DEST_HI = 23;
    localparam int CTL_DEST_LO = 16;
    localparam int CTL_AGE_HI  = 15;
    localparam int CTL_AGE_LO  = 0;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [AGE_W-1:0]  age;
        logic [DATA_W-1:0] data;
    } flit_t;

    // Reserved bits [26:24] are always driven as zero.
    function automatic logic [CONTROL_W-1:0] make_ctl(input logic [DEST_W-1:0] dest,
                                                      input logic [AGE_W-1:0]  age);
        return {1'b1, 3'b000, dest, age};
    endfunction

endpackage

// File: rtl/bless_ni_if.sv
// Node/router-facing signal bundle of bless_ni; master is the environment
// (node + router), slave is the network interface itself.
interface bless_ni_if;
    import bless_ni_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [DEST_W-1:0]    in_dest;
    logic [DATA_W-1:0]    in_data;

    logic [CONTROL_W-1:0] inj_ci;
    logic [DATA_W-1:0]    inj_di;
    logic                 inj_ready;

    logic [CONTROL_W-1:0] ej_ci;
    logic [DATA_W-1:0]    ej_di;

    logic                 out_valid;
    logic [DEST_W-1:0]    out_dest;
    logic [AGE_W-1:0]     out_age;
    logic [DATA_W-1:0]    out_data;

    modport master (
        output in_valid, in_dest, in_data, inj_ready, ej_ci, ej_di,
        input  in_ready, inj_ci, inj_di, out_valid, out_dest, out_age, out_data
    );

    modport slave (
        input  in_valid, in_dest, in_data, inj_ready, ej_ci, ej_di,
        output in_ready, inj_ci, inj_di, out_valid, out_dest, out_age, out_data
    );

endinterface

// File: rtl/bless_ni_fifo.sv
// Injection queue: DEPTH entries of {dest, age, data}. The caller gates
// push with !full and pop with !empty.
module bless_ni_fifo
    import bless_ni_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  flit_t                    wr_flit,
    input  logic                     pop,
    output flit_t                    rd_flit,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    flit_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_flit;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_flit = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/bless_ni.sv
// Network interface on router local port 4: age-stamped injection queue
// toward port4_ci/di and a two-stage ejection capture toward the node.
module bless_ni
    import bless_ni_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    bless_ni_if.slave   ni
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [AGE_W-1:0]     age_ctr;
    flit_t                wr_flit;
    flit_t                head_flit;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [CNT_W-1:0]     count;

    logic                 vld_p0;
    logic [CONTROL_W-1:0] ctl_p0;
    logic [DATA_W-1:0]    data_p0;
    logic [DATA_W-1:0]    data_p1;

    logic                 ej_vld_p0;
    logic [DEST_W-1:0]    ej_dest_p0;
    logic [AGE_W-1:0]     ej_age_p0;
    logic                 out_vld_p1;
    logic [DEST_W-1:0]    out_dest_p1;
    logic [AGE_W-1:0]     out_age_p1;
    logic [DATA_W-1:0]    out_data_p1;

    // Refusal at full holds even if a pop happens in the same cycle.
    assign ni.in_ready = (count != CNT_W'(DEPTH));
    assign push        = ni.in_valid && !full;
    assign pop         = ni.inj_ready && !empty;
    assign wr_flit     = '{dest: ni.in_dest, age: age_ctr, data: ni.in_data};

    bless_ni_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_flit (wr_flit),
        .pop     (pop),
        .rd_flit (head_flit),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            age_ctr <= '0;
        end else begin
            age_ctr <= age_ctr + AGE_W'(1);
        end
    end

    // Stage p0: control word out the cycle after the pop; p1: data beat one later.
    always_ff @(posedge clk) begin
        data_p0 <= head_flit.data;
        if (rst) begin
            vld_p0  <= 1'b0;
            ctl_p0  <= '0;
            data_p1 <= '0;
        end else begin
            vld_p0  <= pop;
            ctl_p0  <= pop ? make_ctl(head_flit.dest, head_flit.age) : '0;
            data_p1 <= vld_p0 ? data_p0 : '0;
        end
    end

    assign ni.inj_ci = ctl_p0;
    assign ni.inj_di = data_p1;

    // Stage p0: latch ejected header; p1: join with its data beat and present.
    always_ff @(posedge clk) begin
        ej_dest_p0 <= ni.ej_ci[CTL_DEST_HI:CTL_DEST_LO];
        ej_age_p0  <= ni.ej_ci[CTL_AGE_HI:CTL_AGE_LO];
        if (rst) begin
            ej_vld_p0   <= 1'b0;
            out_vld_p1  <= 1'b0;
            out_dest_p1 <= '0;
            out_age_p1  <= '0;
            out_data_p1 <= '0;
        end else begin
            ej_vld_p0  <= ni.ej_ci[CTL_VALID];
            out_vld_p1 <= ej_vld_p0;
            if (ej_vld_p0) begin
                out_dest_p1 <= ej_dest_p0;
                out_age_p1  <= ej_age_p0;
                out_data_p1 <= ni.ej_di;
            end
        end
    end

    assign ni.out_valid = out_vld_p1;
    assign ni.out_dest  = out_dest_p1;
    assign ni.out_age   = out_age_p1;
    assign ni.out_data  = out_data_p1;

endmodule

// File: tb/tb_bless_ni.sv
// Randomized and directed bench for bless_ni against a cycle-indexed
// reference model built from queues and schedule tables.
module tb_bless_ni;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0]   dest;
        logic [15:0]  age;
        logic [127:0] data;
    } mflit_t;

    logic clk;
    logic rst;
    bless_ni_if bi ();

    bless_ni #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .ni  (bi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: cycle index, age seen by pushes this cycle,
    // the queue contents and what each future cycle should show.
    int            cyc    = 0;
    bit            chk_on = 0;
    logic [15:0]   m_age  = '0;
    mflit_t        q[$];
    logic [27:0]   exp_ci [int];
    logic [127:0]  exp_di [int];
    logic [23:0]   ej_ctl [int];
    logic [127:0]  ej_dat [int];
    logic [7:0]    hold_dest = '0;
    logic [15:0]   hold_age  = '0;
    logic [127:0]  hold_data = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check what this cycle should show, drive this
    // cycle's inputs, then advance the model across the closing edge.
    task automatic step(input logic r, input logic iv, input logic [7:0] d,
                        input logic [127:0] dat, input logic ir,
                        input logic [27:0] ec, input logic [127:0] ed);
        bit     do_push;
        bit     do_pop;
        mflit_t f;
        @(negedge clk);
        if (chk_on) begin
            if (ej_ctl.exists(cyc)) begin
                hold_dest = ej_ctl[cyc][23:16];
                hold_age  = ej_ctl[cyc][15:0];
                hold_data = ej_dat[cyc];
            end
            chk("in_ready", 128'(bi.in_ready), 128'(q.size() != DEPTH));
            chk("inj_ci", 128'(bi.inj_ci), exp_ci.exists(cyc) ? 128'(exp_ci[cyc]) : 128'(0));
            chk("inj_di", bi.inj_di, exp_di.exists(cyc) ? exp_di[cyc] : 128'(0));
            chk("out_valid", 128'(bi.out_valid), 128'(ej_ctl.exists(cyc)));
            chk("out_dest", 128'(bi.out_dest), 128'(hold_dest));
            chk("out_age", 128'(bi.out_age), 128'(hold_age));
            chk("out_data", bi.out_data, hold_data);
        end
        rst          = r;
        bi.in_valid  = iv;
        bi.in_dest   = d;
        bi.in_data   = dat;
        bi.inj_ready = ir;
        bi.ej_ci     = ec;
        bi.ej_di     = ed;
        if (r) begin
            q.delete();
            exp_ci.delete();
            exp_di.delete();
            ej_ctl.delete();
            ej_dat.delete();
            hold_dest = '0;
            hold_age  = '0;
            hold_data = '0;
            m_age     = '0;
            chk_on    = 1;
        end else begin
            do_pop  = ir && (q.size() != 0);
            do_push = iv && (q.size() != DEPTH);
            if (do_pop) begin
                f = q.pop_front();
                exp_ci[cyc + 1] = {1'b1, 3'b000, f.dest, f.age};
                exp_di[cyc + 2] = f.data;
            end
            if (do_push) q.push_back('{dest: d, age: m_age, data: dat});
            if (ec[27]) ej_ctl[cyc + 2] = ec[23:0];
            if (ej_ctl.exists(cyc + 1)) ej_dat[cyc + 1] = ed;
            m_age = m_age + 16'd1;
        end
        cyc++;
    endtask

    task automatic idle(input logic ir);
        step(1'b0, 1'b0, 8'h00, 128'h0, ir, 28'h0, 128'h0);
    endtask

    task automatic push1(input logic [7:0] d, input logic [127:0] dat, input logic ir);
        step(1'b0, 1'b1, d, dat, ir, 28'h0, 128'h0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] pay;
    logic [127:0] pay_a;
    logic [127:0] pay_b;
    logic         r_rnd;
    logic         ir_rnd;
    logic [27:0]  ec_rnd;

    initial begin
        rst = 1'b1;
        bi.in_valid = 1'b0; bi.in_dest = '0; bi.in_data = '0;
        bi.inj_ready = 1'b0; bi.ej_ci = '0; bi.ej_di = '0;

        step(1'b1, 1'b0, 8'h00, 128'h0, 1'b0, 28'h0, 128'h0);

        // Idle after reset, then a single flit pushed at age 5.
        for (int i = 0; i < 5; i++) idle(1'b1);
        pay = 128'h0123456789abcdef0123456789abcdef;
        push1(8'h04, pay, 1'b1);
        idle(1'b1);
        after_edge();
        chk("plan_ctl_age5", 128'(bi.inj_ci), 128'(28'h8040005));
        idle(1'b1);
        after_edge();
        chk("plan_data_age5", bi.inj_di, pay);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Fill with router stalled, overflow attempt, then push+pop at full.
        for (int i = 0; i < 4; i++) push1(8'h10 + 8'(i), {4{$urandom}}, 1'b0);
        after_edge();
        chk("plan_full_ready", 128'(bi.in_ready), 128'(0));
        push1(8'h55, {4{$urandom}}, 1'b0);
        push1(8'h66, {4{$urandom}}, 1'b1);
        after_edge();
        chk("plan_pushpop_full_ready", 128'(bi.in_ready), 128'(1));
        for (int i = 0; i < 6; i++) idle(1'b1);

        // Back-to-back ejections.
        pay_a = {$urandom, $urandom, $urandom, $urandom};
        pay_b = {$urandom, $urandom, $urandom, $urandom};
        step(1'b0, 1'b0, 8'h00, 128'h0, 1'b0, 28'h8010001, 128'h0);
        step(1'b0, 1'b0, 8'h00, 128'h0, 1'b0, 28'h8060003, pay_a);
        after_edge();
        chk("plan_ej_a_valid", 128'(bi.out_valid), 128'(1));
        chk("plan_ej_a_dest", 128'(bi.out_dest), 128'(8'h01));
        chk("plan_ej_a_data", bi.out_data, pay_a);
        step(1'b0, 1'b0, 8'h00, 128'h0, 1'b0, 28'h0, pay_b);
        after_edge();
        chk("plan_ej_b_age", 128'(bi.out_age), 128'(16'h0003));
        chk("plan_ej_b_data", bi.out_data, pay_b);
        idle(1'b0);
        idle(1'b0);

        // Reset with flits queued, a data beat pending and an ejection in flight.
        for (int i = 0; i < 3; i++) push1(8'h20 + 8'(i), {4{$urandom}}, 1'b0);
        step(1'b0, 1'b0, 8'h00, 128'h0, 1'b1, 28'h8020007, 128'h0);
        step(1'b1, 1'b1, 8'h77, {4{$urandom}}, 1'b1, 28'h8030009, {4{$urandom}});
        after_edge();
        chk("plan_rst_inj_ci", 128'(bi.inj_ci), 128'(0));
        chk("plan_rst_inj_di", bi.inj_di, 128'(0));
        chk("plan_rst_out_valid", 128'(bi.out_valid), 128'(0));
        chk("plan_rst_in_ready", 128'(bi.in_ready), 128'(1));
        for (int i = 0; i < 4; i++) idle(1'b1);
        push1(8'hAB, {4{$urandom}}, 1'b1);
        idle(1'b1);
        after_edge();
        chk("plan_age_restart", 128'(bi.inj_ci), 128'(28'h8AB0004));
        idle(1'b1);
        idle(1'b1);

        // Random traffic: stalled router first, then mostly ready.
        for (int i = 0; i < 600; i++) begin
            r_rnd  = ($urandom_range(0, 99) == 0);
            ir_rnd = ($urandom_range(0, 3) < ((i < 300) ? 1 : 3));
            if ($urandom_range(0, 2) == 0)
                ec_rnd = {1'b1, 3'b000, 8'($urandom), 16'($urandom)};
            else
                ec_rnd = {4'b0000, 24'($urandom)};
            step(r_rnd, 1'($urandom_range(0, 1)), 8'($urandom),
                 {$urandom, $urandom, $urandom, $urandom}, ir_rnd,
                 ec_rnd, {$urandom, $urandom, $urandom, $urandom});
        end
        for (int i = 0; i < 8; i++) idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
